// File: rtl/uart_word_pkg.sv
// Shared defaults and types for the UART word link.
package uart_word_pkg;

  localparam int N_BYTES_DEF     = 16;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT_END
  } tx_state_t;

endpackage

// File: rtl/uart_word_tx.sv
// TX word serializer: splits a captured word into bytes, LSB first, and
// handshakes each one with a UART byte transmitter through its busy flag.
module uart_word_tx
  import uart_word_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   txw_valid,
  output logic                   txw_ready,
  input  logic [8*N_BYTES-1:0]   txw_data,
  input  logic                   tx_busy,
  output logic                   tx_data_en,
  output logic [7:0]             tx_data
);

  localparam int IDX_W = $clog2(N_BYTES);

  tx_state_t              state, state_nxt;
  logic [8*N_BYTES-1:0]   word_q;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_inc;
  logic                   load_word;
  logic                   advance;

  assign idx_inc = idx + IDX_W'(1);

  always_comb begin
    state_nxt  = state;
    load_word  = 1'b0;
    advance    = 1'b0;
    txw_ready  = 1'b0;
    tx_data_en = 1'b0;
    case (state)
      TX_IDLE: begin
        txw_ready = 1'b1;
        if (txw_valid) begin
          load_word = 1'b1;
          state_nxt = TX_REQ;
        end
      end
      // The request drops as soon as the transmitter reports busy.
      TX_REQ: begin
        tx_data_en = ~tx_busy;
        if (tx_busy) state_nxt = TX_WAIT_END;
      end
      TX_WAIT_END: begin
        if (!tx_busy) begin
          if (idx == IDX_W'(N_BYTES - 1)) begin
            state_nxt = TX_IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = TX_REQ;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // tx_data is only reloaded on the transitions that enter TX_REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      word_q  <= '0;
      idx     <= '0;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      if (load_word) begin
        word_q  <= txw_data;
        idx     <= '0;
        tx_data <= txw_data[7:0];
      end else if (advance) begin
        idx     <= idx_inc;
        tx_data <= word_q[{idx_inc, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/uart_word_link.sv
// Word-level link over a UART byte interface: assembles received bytes into
// words and serializes outgoing words through uart_word_tx.
module uart_word_link
  import uart_word_pkg::*;
#(
  parameter int N_BYTES     = N_BYTES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_data_en,
  input  logic [7:0]             rx_data,
  input  logic                   tx_busy,
  output logic                   tx_data_en,
  output logic [7:0]             tx_data,
  output logic                   rxw_valid,
  input  logic                   rxw_ready,
  output logic [8*N_BYTES-1:0]   rxw_data,
  input  logic                   txw_valid,
  output logic                   txw_ready,
  input  logic [8*N_BYTES-1:0]   txw_data,
  output logic                   err_overrun,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  localparam int CNT_W  = $clog2(N_BYTES);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0]  byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              rxw_fire;
  logic              rx_accept;
  logic              rx_drop;
  logic              rx_last;
  logic              timeout_hit;

  assign rxw_fire    = rxw_valid & rxw_ready;
  assign rx_accept   = rx_data_en & (~rxw_valid | rxw_ready);
  assign rx_drop     = rx_data_en & rxw_valid & ~rxw_ready;
  assign rx_last     = (byte_cnt == CNT_W'(N_BYTES - 1));
  assign timeout_hit = ~rx_data_en & (byte_cnt != '0) &
                       (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // A byte arriving in the handshake cycle starts the next word, so the
  // clear of rxw_valid and the byte write can coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxw_valid <= 1'b0;
      rxw_data  <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
    end else begin
      if (rxw_fire) rxw_valid <= 1'b0;
      if (rx_accept) begin
        rxw_data[{byte_cnt, 3'b000} +: 8] <= rx_data;
        if (rx_last) begin
          byte_cnt  <= '0;
          rxw_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end
      if (rx_data_en || byte_cnt == '0 || timeout_hit) idle_cnt <= '0;
      else                                             idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (rx_drop)      err_overrun <= 1'b1;
      else if (err_clr) err_overrun <= 1'b0;
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  uart_word_tx #(
    .N_BYTES (N_BYTES)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .txw_valid  (txw_valid),
    .txw_ready  (txw_ready),
    .txw_data   (txw_data),
    .tx_busy    (tx_busy),
    .tx_data_en (tx_data_en),
    .tx_data    (tx_data)
  );

endmodule

// File: doc/uart_word_link.md
UART_WORD_LINK -- requirements
Module: uart_word_link

Interface
REQ-001 Parameter N_BYTES, default 16, bytes per word (2..64); WORD_W = 8*N_BYTES.
REQ-002 Parameter TIMEOUT_CYC, default 1000000, idle clocks after which a partial RX word is discarded.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rx_data_en  in  1  one-cycle strobe from UART byte receiver, rx_data valid.
REQ-006 rx_data  in  8  received byte.
REQ-007 tx_busy  in  1  UART byte transmitter busy flag.
REQ-008 tx_data_en  out  1  transmit request to UART byte transmitter (edge-detected downstream).
REQ-009 tx_data  out  8  byte to transmit.
REQ-010 rxw_valid / rxw_ready / rxw_data  out / in / out  1 / 1 / WORD_W  assembled RX word stream.
REQ-011 txw_valid / txw_ready / txw_data  in / out / in  1 / 1 / WORD_W  TX word stream.
REQ-012 err_overrun, err_timeout  out  1 each  sticky error flags; err_clr  in  1  clears both.

Function
REQ-013 RX: byte k of a word (k = 0..N_BYTES-1, k-th rx_data_en) SHALL land in rxw_data[8k+7:8k] (LSB byte first).
REQ-014 rxw_valid SHALL rise the cycle after the rx_data_en of byte N_BYTES-1 and hold, data stable, until rxw_valid & rxw_ready.
REQ-015 rx_data_en while rxw_valid high and rxw_ready low SHALL drop the byte and set err_overrun.
REQ-016 rx_data_en in the same cycle as the rxw handshake SHALL be accepted as byte 0 of the next word.
REQ-017 RX byte counter SHALL wrap to 0 after byte N_BYTES-1; counter width clog2(N_BYTES).
REQ-018 Idle counter SHALL reset on every rx_data_en, count only while 0 < byte count < N_BYTES; on reaching TIMEOUT_CYC it SHALL zero the byte count, discard the partial word and set err_timeout.
REQ-019 err_clr SHALL clear both flags; a same-cycle set event SHALL win over err_clr.
REQ-020 TX FSM states: IDLE, REQ, WAIT_END.
REQ-021 IDLE: txw_ready = 1; on txw_valid & txw_ready capture txw_data, byte index 0, go to REQ next cycle.
REQ-022 REQ: tx_data = captured byte[index], tx_data_en = 1; stay until tx_busy = 1, then go to WAIT_END with tx_data_en = 0 from that cycle on.
REQ-023 WAIT_END: tx_data_en = 0; on tx_busy = 0, if index = N_BYTES-1 go to IDLE, else index+1 and go to REQ.
REQ-024 txw_ready SHALL be 0 in every state except IDLE; tx_data SHALL change only on entry to REQ.
REQ-025 RX and TX paths SHALL be fully independent and operate concurrently.

Reset
REQ-026 On rst: rxw_valid = 0, rxw_data = 0, RX byte count = 0, idle count = 0, err_overrun = 0, err_timeout = 0.
REQ-027 On rst: TX FSM = IDLE, tx_data_en = 0, tx_data = 8'h00, index = 0, txw_ready = 1 the cycle after rst deasserts.
REQ-028 rst mid-word or mid-transmission SHALL abandon the word with no further tx_data_en pulse.

Structure
REQ-029 Package uart_word_pkg SHALL hold N_BYTES and TIMEOUT_CYC defaults and the TX state enum type.
REQ-030 TX path SHALL be a sub-module uart_word_tx; RX assembly stays in the top level.

Verification (bench: N_BYTES = 4, TIMEOUT_CYC = 100, behavioural UART byte model)
REQ-031 RX bytes 11,22,33,44 with rxw_ready = 1 -> one rxw_valid pulse, rxw_data = 32'h44332211, no error flags.
REQ-032 RX 8 bytes 01..08 with rxw_ready = 0 until after byte 8 -> rxw_data = 32'h04030201 held, bytes 05..08 dropped, err_overrun = 1.
REQ-033 RX bytes AA,BB, then 150 idle clocks, then 01,02,03,04 -> err_timeout = 1, rxw_data = 32'h04030201.
REQ-034 txw_data = 32'hDEADBEEF pushed -> UART model sees EF,BE,AD,DE in order, txw_ready low until last tx_busy falls.
REQ-035 rst asserted in WAIT_END after byte 1 -> tx_data_en = 0 and txw_ready = 1 after reset, no further bytes sent.
